// File: rtl/imem_loadable.sv
// Byte-addressable instruction memory with a runtime byte-stream load port and a
// registered 32-bit fetch port that reports misaligned/out-of-range fetches.
module imem_loadable #(
   parameter int unsigned DEPTH_BYTES = 4096,
   parameter int unsigned ADDR_W      = 12,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_err,
   output logic              busy,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [31:0]       fetch_data,
   output logic              fetch_fault
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;

   localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH_BYTES);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic              load_err_q, load_err_d;
   logic              mem_we;
   logic              fetch_valid_q;
   logic [31:0]       fetch_data_q;
   logic              fetch_fault_q;
   logic              fetch_take;
   logic [ADDR_W:0]   last_addr;
   logic              fault_c;
   logic [31:0]       word_c;

   // Standard boot image: addi x1,x0,240 ; addi x2,x1,1. Not touched by reset.
   logic [7:0] mem [DEPTH_BYTES] = '{
      0: 8'h93, 1: 8'h00, 2: 8'h00, 3: 8'h0F,
      4: 8'h13, 5: 8'h81, 6: 8'h10, 7: 8'h00,
      default: 8'h00
   };

   assign load_ready  = (state_q == StLoad) && (wptr_q < DepthW);
   assign load_err    = load_err_q;
   assign busy        = (state_q != StRun);
   assign fetch_valid = fetch_valid_q;
   assign fetch_data  = fetch_data_q;
   assign fetch_fault = fetch_fault_q;

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      load_err_d = load_err_q;
      mem_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d    = StLoad;
               wptr_d     = '0;
               load_err_d = 1'b0;
            end else begin
               state_d = StRun;
            end
         end
         StLoad: begin
            // A restart takes priority over any byte offered in the same cycle.
            if (load_start) begin
               wptr_d     = '0;
               load_err_d = 1'b0;
            end else if (load_valid) begin
               if (load_ready) begin
                  mem_we = 1'b1;
                  wptr_d = wptr_q + (ADDR_W + 1)'(1);
               end else begin
                  load_err_d = 1'b1;
               end
               if (load_last) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (load_start) begin
               state_d    = StLoad;
               wptr_d     = '0;
               load_err_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      last_addr  = {1'b0, fetch_addr} + (ADDR_W + 1)'(3);
      fault_c    = (fetch_addr[1:0] != 2'b00) || (last_addr >= DepthW);
      word_c     = {mem[fetch_addr + ADDR_W'(3)], mem[fetch_addr + ADDR_W'(2)],
                    mem[fetch_addr + ADDR_W'(1)], mem[fetch_addr]};
      fetch_take = (state_q == StRun) && fetch_req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         wptr_q     <= '0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         load_err_q <= load_err_d;
      end
   end

   // Data/fault hold their last value when no fetch is taken; only valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= NOP_WORD;
         fetch_fault_q <= 1'b0;
      end else begin
         fetch_valid_q <= fetch_take;
         if (fetch_take) begin
            fetch_data_q  <= fault_c ? NOP_WORD : word_c;
            fetch_fault_q <= fault_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr_q[ADDR_W-1:0]] <= load_byte;
      end
   end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable (16-byte instance): directed steps plus random
// loads/fetches checked every cycle against a byte-array reference model.
module tb_imem_loadable;

   localparam int unsigned Depth = 16;
   localparam int unsigned Aw    = 4;
   localparam logic [31:0] Nop   = 32'h0000_0013;
   localparam int MIdle = 0;
   localparam int MLoad = 1;
   localparam int MRun  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start, load_valid, load_last;
   logic [7:0]    load_byte;
   logic          load_ready, load_err, busy;
   logic          fetch_req;
   logic [Aw-1:0] fetch_addr;
   logic          fetch_valid, fetch_fault;
   logic [31:0]   fetch_data;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          m_mode;
   int          m_wptr;
   bit          m_err;
   logic [7:0]  m_mem [Depth];
   bit          m_known [Depth];
   bit          e_fv, e_ff, e_known;
   logic [31:0] e_fd;

   always #5 clk = ~clk;

   imem_loadable #(
      .DEPTH_BYTES(Depth),
      .ADDR_W     (Aw),
      .NOP_WORD   (Nop)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_byte  (load_byte),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_err   (load_err),
      .busy       (busy),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_valid(fetch_valid),
      .fetch_data (fetch_data),
      .fetch_fault(fetch_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      load_start = 1'b0;
      load_valid = 1'b0;
      load_byte  = 8'h00;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
   endtask

   task automatic model_reset();
      m_mode  = MIdle;
      m_wptr  = 0;
      m_err   = 1'b0;
      e_fv    = 1'b0;
      e_ff    = 1'b0;
      e_fd    = Nop;
      e_known = 1'b1;
   endtask

   // Applies the inputs currently driven to the model, as one rising edge.
   task automatic model_edge();
      int a;
      bit ready;
      a     = int'(fetch_addr);
      ready = (m_mode == MLoad) && (m_wptr < Depth);
      if (m_mode == MRun && fetch_req) begin
         e_fv = 1'b1;
         if ((a % 4) != 0 || a + 3 >= Depth) begin
            e_ff    = 1'b1;
            e_fd    = Nop;
            e_known = 1'b1;
         end else begin
            e_ff    = 1'b0;
            e_fd    = {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
            e_known = m_known[a] && m_known[a+1] && m_known[a+2] && m_known[a+3];
         end
      end else begin
         e_fv = 1'b0;
      end
      if (m_mode == MIdle) begin
         if (load_start) begin
            m_mode = MLoad; m_wptr = 0; m_err = 1'b0;
         end else begin
            m_mode = MRun;
         end
      end else if (m_mode == MLoad) begin
         if (load_start) begin
            m_wptr = 0; m_err = 1'b0;
         end else if (load_valid) begin
            if (ready) begin
               m_mem[m_wptr]   = load_byte;
               m_known[m_wptr] = 1'b1;
               m_wptr++;
            end else begin
               m_err = 1'b1;
            end
            if (load_last) m_mode = MRun;
         end
      end else if (load_start) begin
         m_mode = MLoad; m_wptr = 0; m_err = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("load_ready", load_ready, (m_mode == MLoad) && (m_wptr < Depth));
      chk("load_err", load_err, m_err);
      chk("busy", busy, m_mode != MRun);
      chk("fetch_valid", fetch_valid, e_fv);
      chk("fetch_fault", fetch_fault, e_ff);
      if (e_known) chk("fetch_data", fetch_data, e_fd);
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [7:0] b, input bit last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      cycle();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch(input int a);
      fetch_req  = 1'b1;
      fetch_addr = a[Aw-1:0];
      cycle();
      fetch_req  = 1'b0;
   endtask

   task automatic rand_load();
      int n;
      int i;
      n = $urandom_range(1, 20);
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      i = 0;
      while (i < n) begin
         load_valid = ($urandom_range(0, 3) != 0);
         load_byte  = 8'($urandom);
         load_last  = load_valid && (i == n - 1);
         fetch_req  = 1'($urandom);
         fetch_addr = Aw'($urandom);
         cycle();
         if (load_valid) i++;
      end
      idle_inputs();
   endtask

   logic [7:0] prog [8];
   logic [7:0] rb [3];
   logic [7:0] old3;

   initial begin
      prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h01};
      for (int i = 0; i < Depth; i++) m_known[i] = 1'b0;
      m_mem[0] = 8'h93; m_mem[1] = 8'h00; m_mem[2] = 8'h00; m_mem[3] = 8'h0F;
      for (int i = 0; i < 4; i++) m_known[i] = 1'b1;
      idle_inputs();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_outputs();
      chk("reset_fetch_data", fetch_data, Nop);

      // Default image
      rst = 1'b0;
      cycle();
      cycle();
      fetch(0);
      chk("default_word0", fetch_data, 32'h0F00_0093);
      chk("default_valid", fetch_valid, 1);

      // Load 8-byte program
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      for (int i = 0; i < 8; i++) send(prog[i], i == 7);
      chk("busy_after_last", busy, 0);
      fetch(4);
      chk("prog_word1", fetch_data, 32'h0150_0593);
      fetch(0);
      chk("prog_word0", fetch_data, 32'h00A0_0513);

      // Misaligned fetch, then hold with no request
      fetch(6);
      chk("misaligned_fault", fetch_fault, 1);
      chk("misaligned_data", fetch_data, 32'h0000_0013);
      cycle();
      chk("hold_valid_low", fetch_valid, 0);
      chk("hold_data", fetch_data, 32'h0000_0013);

      // Fetch during LOAD is ignored; then overflow with 18 bytes
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      fetch(0);
      chk("fetch_in_load", fetch_valid, 0);
      for (int i = 0; i < 18; i++) begin
         send(8'($urandom), i == 17);
         if (i == 15) chk("ovf_ready_low", load_ready, 0);
         if (i == 16) chk("ovf_err", load_err, 1);
      end
      chk("ovf_reaches_run", busy, 0);
      chk("ovf_err_sticky", load_err, 1);

      // Back-to-back fetches
      fetch_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_addr = Aw'(4 * i);
         cycle();
         chk("b2b_valid", fetch_valid, 1);
         chk("b2b_data", fetch_data,
             {m_mem[4*i+3], m_mem[4*i+2], m_mem[4*i+1], m_mem[4*i]});
      end
      fetch_req = 1'b0;
      cycle();

      // RUN->LOAD with a same-cycle fetch: served, later ones ignored
      load_start = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = '0;
      cycle();
      chk("run_to_load_served", fetch_valid, 1);
      load_start = 1'b0;
      cycle();
      chk("run_to_load_ignored", fetch_valid, 0);
      fetch_req = 1'b0;
      for (int i = 0; i < 12; i++) send(8'($urandom), i == 11);

      // Random loads and fetches
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            rand_load();
         end else begin
            fetch($urandom_range(0, Depth - 1));
         end
      end

      // Reset in the middle of a load
      old3 = m_mem[3];
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rb[i] = 8'($urandom);
         send(rb[i], 1'b0);
      end
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chk("midload_ready", load_ready, 0);
      chk("midload_busy", busy, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle();
      cycle();
      fetch(0);
      chk("midload_word0", fetch_data, {old3, rb[2], rb[1], rb[0]});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
